// File: rtl/div_request_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_request_sequencer_pkg
//  Description : Shared types and constants for the divider request
//                sequencer: the FSM state encoding, the saturated quotient
//                values and the output scale, plus the helper that picks
//                the value handed downstream when the divider flags trouble.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_request_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Q-format words: number in [15:3], scale factor 3 in [2:0].
   localparam logic [15:0] SAT_POS   = 16'h7FFB;  // largest positive number
   localparam logic [15:0] SAT_NEG   = 16'h8003;  // most negative number
   localparam logic [15:0] ZERO_Q    = 16'h0003;  // 0 / 0 result
   localparam int          OUT_SCALE = 3;

   // Divide-by-zero is checked first: the divider reports it without a
   // meaningful quotient, and its sign comes from the dividend alone.
   function automatic logic [15:0] saturate_q(
      input logic [15:0] q,
      input logic        ovf,
      input logic        dbz,
      input logic        sign,
      input logic        dsign,
      input logic        dvd_zero
   );
      if (dbz) begin
         if (dvd_zero) return ZERO_Q;
         return dsign ? SAT_NEG : SAT_POS;
      end
      if (ovf) return sign ? SAT_NEG : SAT_POS;
      return q;
   endfunction

endpackage : div_request_sequencer_pkg
`default_nettype wire

// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : div_request_sequencer
//  Description : Control stage around the iterative Q-format divider.
//                Accepts an operand pair (valid/ready), registers it,
//                pulses div_start for one cycle, waits for div_ready under a
//                watchdog, captures (and optionally saturates) the quotient,
//                and holds it until the consumer takes it.
//  Ports       : clk, reset (async, active low)
//                req_valid/req_ready/req_dividend/req_divisor  - request side
//                div_start/div_dividend/div_divisor            - divider load
//                div_q/div_ready/div_overflow/div_dbz          - divider result
//                res_valid/res_ready/res_q/res_ovf/res_dbz/res_tmo - result
//                ops_done                                      - handoff count
//  Revision    : 1.0 - initial release
// ============================================================================
module div_request_sequencer
   import div_request_sequencer_pkg::*;
#(
   parameter int N        = 16,
   parameter int TIMEOUT  = 40,
   parameter int SATURATE = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [N-1:0]  req_dividend,
   input  logic [N-1:0]  req_divisor,
   output logic          div_start,
   output logic [N-1:0]  div_dividend,
   output logic [N-1:0]  div_divisor,
   input  logic [N-1:0]  div_q,
   input  logic          div_ready,
   input  logic          div_overflow,
   input  logic          div_dbz,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [N-1:0]  res_q,
   output logic          res_ovf,
   output logic          res_dbz,
   output logic          res_tmo,
   output logic [15:0]   ops_done
);

   localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [WDOG_W-1:0] r_wdog;
   logic [N-1:0]      r_dividend;
   logic [N-1:0]      r_divisor;
   logic              r_sign;
   logic              r_dsign;
   logic              r_res_valid;
   logic [N-1:0]      r_res_q;
   logic              r_res_ovf;
   logic              r_res_dbz;
   logic              r_res_tmo;
   logic [15:0]       r_ops_done;
   logic              w_wdog_expired;
   logic [N-1:0]      w_capture_q;

   assign w_wdog_expired = (r_wdog == WDOG_LAST);

   // Quotient taken at capture; the dividend-zero test looks only at the
   // number field so the scale bits never mask a 0/0 case.
   assign w_capture_q = (SATURATE != 0)
                      ? saturate_q(div_q, div_overflow, div_dbz, r_sign, r_dsign,
                                   (r_dividend[N-1:OUT_SCALE] == '0))
                      : div_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_next_state = START;
         START:   w_next_state = WAIT;
         WAIT:    if (div_ready || w_wdog_expired) w_next_state = HOLD;
         HOLD:    if (res_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      req_ready = 1'b0;
      div_start = 1'b0;
      case (r_state)
         IDLE:    req_ready = 1'b1;
         START:   div_start = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdog      <= '0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_sign      <= 1'b0;
         r_dsign     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_q     <= '0;
         r_res_ovf   <= 1'b0;
         r_res_dbz   <= 1'b0;
         r_res_tmo   <= 1'b0;
         r_ops_done  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_dividend <= req_dividend;
                  r_divisor  <= req_divisor;
                  r_sign     <= req_dividend[N-1] ^ req_divisor[N-1];
                  r_dsign    <= req_dividend[N-1];
               end
            end
            START: r_wdog <= '0;
            WAIT: begin
               r_wdog <= r_wdog + 1'b1;
               // A finishing divider wins over a watchdog expiring on the
               // same edge.
               if (div_ready) begin
                  r_res_valid <= 1'b1;
                  r_res_q     <= w_capture_q;
                  r_res_ovf   <= div_overflow;
                  r_res_dbz   <= div_dbz;
               end else if (w_wdog_expired) begin
                  r_res_valid <= 1'b1;
                  r_res_q     <= '0;
                  r_res_tmo   <= 1'b1;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_ovf   <= 1'b0;
                  r_res_dbz   <= 1'b0;
                  r_res_tmo   <= 1'b0;
                  r_ops_done  <= r_ops_done + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign res_valid    = r_res_valid;
   assign res_q        = r_res_q;
   assign res_ovf      = r_res_ovf;
   assign res_dbz      = r_res_dbz;
   assign res_tmo      = r_res_tmo;
   assign ops_done     = r_ops_done;

endmodule : div_request_sequencer
`default_nettype wire

// File: tb/tb_div_request_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_request_sequencer
//  Description : Bench for div_request_sequencer with a behavioural divider
//                stand-in whose completion latency is programmable
//                (0 = never completes) and a reference model that derives
//                the expected quotient, flags and latency from operand values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_request_sequencer;

   localparam int N       = 16;
   localparam int TIMEOUT = 40;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  req_dividend;
   logic [N-1:0]  req_divisor;
   logic          div_start;
   logic [N-1:0]  div_dividend;
   logic [N-1:0]  div_divisor;
   logic [N-1:0]  div_q;
   logic          div_ready;
   logic          div_overflow;
   logic          div_dbz;
   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  res_q;
   logic          res_ovf;
   logic          res_dbz;
   logic          res_tmo;
   logic [15:0]   ops_done;

   div_request_sequencer #(.N(N), .TIMEOUT(TIMEOUT), .SATURATE(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dividend (req_dividend),
      .req_divisor  (req_divisor),
      .div_start    (div_start),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_q        (div_q),
      .div_ready    (div_ready),
      .div_overflow (div_overflow),
      .div_dbz      (div_dbz),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_q        (res_q),
      .res_ovf      (res_ovf),
      .res_dbz      (res_dbz),
      .res_tmo      (res_tmo),
      .ops_done     (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- divider stand-in ----------------
   int          stub_lat = 0;
   int          s_cnt    = 0;
   logic        s_rdy    = 1'b0;
   logic        s_ovf    = 1'b0;
   logic        s_dbz    = 1'b0;
   logic [15:0] s_q      = 16'h0;

   function automatic logic [15:0] stub_quot(input logic [15:0] a, input logic [15:0] b);
      int an;
      int bn;
      int qi;
      logic [31:0] qv;
      an = int'($signed(a[15:3]));
      bn = int'($signed(b[15:3]));
      if (bn == 0) return 16'hDEAD;
      qi = (an * 8) / bn;
      if (qi > 4095 || qi < -4096) return 16'hBEEF;
      qv = qi;
      return {qv[12:0], 3'b011};
   endfunction

   function automatic logic stub_ovf(input logic [15:0] a, input logic [15:0] b);
      int an;
      int bn;
      int qi;
      an = int'($signed(a[15:3]));
      bn = int'($signed(b[15:3]));
      if (bn == 0) return 1'b0;
      qi = (an * 8) / bn;
      return (qi > 4095 || qi < -4096);
   endfunction

   // Loads on the start pulse, clears ready on that edge, and raises ready
   // stub_lat edges later; ready then stays high until the next load.
   always @(posedge clk) begin
      if (div_start) begin
         s_rdy <= 1'b0;
         s_cnt <= stub_lat;
         s_q   <= stub_quot(div_dividend, div_divisor);
         s_ovf <= stub_ovf(div_dividend, div_divisor);
         s_dbz <= (div_divisor[15:3] == 13'd0);
      end else if (s_cnt == 1) begin
         s_cnt <= 0;
         s_rdy <= 1'b1;
      end else if (s_cnt > 1) begin
         s_cnt <= s_cnt - 1;
      end
   end

   assign div_ready    = s_rdy;
   assign div_q        = s_q;
   assign div_overflow = s_ovf;
   assign div_dbz      = s_dbz;

   // ---------------- checking ----------------
   int passed = 0;
   int failed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] exp_q;
   logic        exp_ovf;
   logic        exp_dbz;
   logic        exp_tmo;
   int          exp_lat;
   int          exp_ops = 0;

   task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input int lat);
      int  an;
      int  bn;
      int  qi;
      real r;
      logic [31:0] qv;
      an = int'($signed(a[15:3]));
      bn = int'($signed(b[15:3]));
      exp_ovf = 1'b0;
      exp_dbz = 1'b0;
      exp_tmo = 1'b0;
      // Ready first seen at edge lat+2 after the accept edge; the watchdog
      // ends the wait at edge TIMEOUT+1.
      if (lat == 0 || lat >= TIMEOUT) begin
         exp_tmo = 1'b1;
         exp_q   = 16'h0000;
         exp_lat = TIMEOUT + 1;
      end else begin
         exp_lat = lat + 2;
         if (bn == 0) begin
            exp_dbz = 1'b1;
            exp_q   = (an == 0) ? 16'h0003 : (a[15] ? 16'h8003 : 16'h7FFB);
         end else begin
            r  = real'(an * 8) / real'(bn);
            qi = $rtoi(r);
            if (qi > 4095 || qi < -4096) begin
               exp_ovf = 1'b1;
               exp_q   = (a[15] ^ b[15]) ? 16'h8003 : 16'h7FFB;
            end else begin
               qv    = qi;
               exp_q = {qv[12:0], 3'b011};
            end
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctl"}, {58'd0, req_ready, div_start, res_valid, res_ovf, res_dbz, res_tmo},
            {58'd0, 6'b100000});
      check({tag, "_data"}, {res_q, div_dividend, div_divisor, ops_done}, 64'd0);
   endtask

   // One transaction, entered and left one time unit after a rising edge.
   // hold_rst asserts the async reset while the result is being held
   // instead of letting the consumer take it.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int lat,
                        input int bp, input bit hold_rst, input string tag);
      int cycles;
      int n_start;
      ref_model(a, b, lat);
      stub_lat     = lat;
      req_dividend = a;
      req_divisor  = b;
      req_valid    = 1'b1;
      res_ready    = 1'b0;
      check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_dividend = 16'h0;
      req_divisor  = 16'h0;
      check({tag, "_launch"}, {31'd0, div_start, div_dividend, div_divisor}, {31'd1, a, b});
      cycles  = 0;
      n_start = 0;
      while (!res_valid && cycles < 200) begin
         @(posedge clk); #1;
         cycles = cycles + 1;
         if (div_start) n_start = n_start + 1;
      end
      check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
      check({tag, "_single_start"}, 64'(n_start), 64'd0);
      check({tag, "_result"}, {44'd0, res_valid, res_q, res_ovf, res_dbz, res_tmo},
            {44'd0, 1'b1, exp_q, exp_ovf, exp_dbz, exp_tmo});
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, "_hold"}, {42'd0, res_valid, req_ready, div_start, res_q, res_ovf, res_dbz, res_tmo},
               {42'd0, 3'b100, exp_q, exp_ovf, exp_dbz, exp_tmo});
      end
      req_valid = 1'b0;
      if (hold_rst) begin
         #3;
         reset = 1'b0;
         #1;
         exp_ops = 0;
         check_reset_state({tag, "_hold_reset"});
         @(posedge clk); #1;
         reset = 1'b1;
      end else begin
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0;
         exp_ops   = exp_ops + 1;
         check({tag, "_release"}, {59'd0, res_valid, req_ready, res_ovf, res_dbz, res_tmo},
               {59'd0, 5'b01000});
         check({tag, "_ops_done"}, {48'd0, ops_done}, 64'(exp_ops & 16'hFFFF));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] a;
      logic [15:0] b;
      reset        = 1'b0;
      req_valid    = 1'b0;
      res_ready    = 1'b0;
      req_dividend = 16'h0;
      req_divisor  = 16'h0;
      #2;
      check_reset_state("reset_pre_clock");
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_clocked");
      reset = 1'b1;

      // Directed cases
      do_op(16'h0183, 16'h0083, 17, 0, 1'b0, "nominal");
      do_op(16'hFE83, 16'h0083, 17, 0, 1'b0, "negative");
      do_op(16'h0183, 16'h0003, 17, 0, 1'b0, "dbz_pos");
      do_op(16'hFE83, 16'h0003, 17, 0, 1'b0, "dbz_neg");
      do_op(16'h0003, 16'h0003, 17, 0, 1'b0, "dbz_zero");
      do_op(16'h7FFB, 16'h000B, 17, 0, 1'b0, "ovf_pos");
      do_op(16'h7FFB, 16'hFFFB, 17, 0, 1'b0, "ovf_neg");
      do_op(16'h0183, 16'h0083, 17, 10, 1'b0, "backpressure");
      do_op(16'h0183, 16'h0083, 0, 2, 1'b0, "timeout");
      do_op(16'h0183, 16'h0083, TIMEOUT - 1, 0, 1'b0, "ready_at_timeout");
      do_op(16'h0183, 16'h0083, TIMEOUT, 0, 1'b0, "ready_after_timeout");
      do_op(16'h0183, 16'h0083, 1, 0, 1'b0, "fast_divider");

      // Async reset in the middle of WAIT, with no clock edge involved
      stub_lat     = 0;
      req_dividend = 16'h0183;
      req_divisor  = 16'h0083;
      req_valid    = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      exp_ops = 0;
      check_reset_state("wait_reset");
      @(posedge clk); #1;
      reset = 1'b1;
      do_op(16'hFE83, 16'h0083, 17, 0, 1'b0, "after_wait_reset");

      // Async reset while a result is held
      do_op(16'h0183, 16'h0083, 5, 3, 1'b1, "hold_reset");
      do_op(16'h0183, 16'h0083, 17, 0, 1'b0, "after_hold_reset");

      // Randomized operands, divider latency and backpressure
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 5) == 0) b[15:3] = 13'd0;
         else if ($urandom_range(0, 3) == 0) b[15:3] = 13'($urandom_range(0, 15)) - 13'd8;
         do_op(a, b, $urandom_range(1, TIMEOUT - 1), $urandom_range(0, 4), 1'b0, "random");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_div_request_sequencer
`default_nettype wire

// File: doc/div_request_sequencer.md
Name: div_request_sequencer

Overview:
- Upstream/downstream control stage wrapped around the iterative 16-bit Q-format divider (Division_CSA).
- Accepts dividend/divisor pairs from the ODE datapath over a valid/ready handshake and launches the divider. The launch is a one-cycle pulse on the divider's active-high "reset" (load/start) input.
- Waits for the divider's ready and captures Q with its flags. Optionally substitutes saturated values on overflow or divide-by-zero, and holds the result until the consumer takes it.
- Adds a timeout watchdog and a completed-operation counter.

Parameters:
- N, 16, operand/result width; format is signed number in [N-1:3], scale factor in [2:0].
- TIMEOUT, 40, maximum WAIT cycles before the operation is aborted with a timeout flag.
- SATURATE, 1, 1 = replace result on overflow or divide-by-zero with a saturated value; 0 = pass div_q through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  operand pair valid
- req_ready  out  1  sequencer can accept a pair
- req_dividend  in  N  dividend (Q format)
- req_divisor  in  N  divisor (Q format)
- div_start  out  1  one-cycle load pulse to the divider's reset input
- div_dividend  out  N  registered dividend to the divider
- div_divisor  out  N  registered divisor to the divider
- div_q  in  N  divider quotient
- div_ready  in  1  divider done
- div_overflow  in  1  divider overflow flag
- div_dbz  in  1  divider divide-by-zero flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_q  out  N  result (Q format, scale 3)
- res_ovf  out  1  overflow occurred
- res_dbz  out  1  divide-by-zero occurred
- res_tmo  out  1  timeout occurred
- ops_done  out  16  count of results handed off; wraps from 16'hFFFF to 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - div_dividend, div_divisor, ops_done and the watchdog counter all 0.
- req_ready = (state==IDLE), combinational from state.
- IDLE:
  - On req_valid&&req_ready at an edge, register operands into div_dividend/div_divisor.
  - Latch sign = req_dividend[N-1]^req_divisor[N-1] and dsign = req_dividend[N-1].
  - Go to START.
- START:
  - div_start=1 for exactly this one cycle; operands are stable on div_* during it.
  - Next edge goes to WAIT with the watchdog counter cleared. The divider clears its ready at this same edge.
- WAIT:
  - div_start=0; the counter increments each cycle.
  - If div_ready=1 at an edge: capture div_q, div_overflow and div_dbz; go to HOLD with res_valid=1.
  - Else if counter==TIMEOUT-1: go to HOLD with res_tmo=1, res_q=0, res_valid=1.
  - div_ready has priority over timeout in the same cycle.
- Saturation (SATURATE=1, evaluated at capture):
  - Overflow: res_q = sign ? 16'h8003 : 16'h7FFB.
  - Divide-by-zero: res_q = dsign ? 16'h8003 : 16'h7FFB; if the dividend number field [N-1:3] is 0, res_q = 16'h0003.
  - Flags are still reported.
  - SATURATE=0: res_q=div_q, flags only.
- HOLD:
  - res_* stable while res_valid=1 && res_ready=0.
  - On res_ready at an edge: res_valid=0, clear res_ovf/res_dbz/res_tmo, ops_done+1, go to IDLE.
  - req_valid is ignored in HOLD; no back-to-back bypass.
- Latency: handshake at edge E0, div_start high during E0..E1. If the divider first shows ready in the cycle after edge Ek, res_valid rises at edge Ek+1.
  - The nominal divider (16 iterations + 1 finish cycle) makes this 19 cycles from E0.
- Async reset mid-WAIT or mid-HOLD:
  - Return to IDLE immediately and drop any result.
  - The divider is not reset by this block; the next div_start reloads it.
- Any div_ready that is not observed in WAIT is ignored.

Decomposition:
- Shared package holds:
  - state enum IDLE/START/WAIT/HOLD (2 bits);
  - constants SAT_POS=16'h7FFB, SAT_NEG=16'h8003, ZERO_Q=16'h0003;
  - OUT_SCALE=3.
- No sub-module needed; the watchdog is an inline counter.
- The top-level ODE datapath instantiates this block alongside Division_CSA.

Test Plan:
- Nominal divide with the real Division_CSA: dividend 16'h0183 (6.0), divisor 16'h0083 (2.0) -> res_q=16'h00C3 (3.0), all flags 0, res_valid 19 cycles after accept, ops_done=1.
- Negative quotient: dividend 16'hFE83 (-6.0), divisor 16'h0083 -> res_q=16'hFF43 (-3.0).
- Divide-by-zero: divisor 16'h0003, dividend 16'h0183 -> res_dbz=1, res_q=16'h7FFB; with dividend 16'h0003 -> res_q=16'h0003.
- Backpressure: hold res_ready=0 for 10 cycles -> res_* stable and req_ready=0 throughout; release -> IDLE next cycle, ops_done increments once.
- Timeout: stub divider that never raises ready -> res_tmo=1, res_q=0, res_valid exactly TIMEOUT cycles after entering WAIT.
- Async reset asserted mid-WAIT -> outputs return to reset values with no clock edge; a following request completes normally with the correct quotient.
